// File: rtl/mem_port_arbiter_pkg.sv
// Shared CPU memory-port definitions: bus width defaults and the
// read-owner encoding used to tag returning RAM data.
package mem_port_arbiter_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_MS   = 2'd2
    } owner_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter between fetch (read-only) and memory stage.
// Memory stage wins ties; a burst counter bounds how long fetch can starve.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int MAX_MS_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ms_req,
    input  logic              ms_we,
    input  logic [ADDR_W-1:0] ms_addr,
    input  logic [DATA_W-1:0] ms_wdata,
    output logic              ms_gnt,
    output logic              ms_rvalid,
    output logic [DATA_W-1:0] ms_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam logic [3:0] LP_MAX = 4'(MAX_MS_BURST);

    logic [3:0] r_burst_cnt;
    owner_e     r_rd_owner;
    logic       w_open;
    logic       w_ms_win;
    logic       w_if_win;

    always_comb begin
        w_open   = !rst && !freeze;
        w_ms_win = w_open && ms_req
                   && (!if_req || (r_burst_cnt < LP_MAX));
        w_if_win = w_open && if_req && !w_ms_win;
    end

    assign if_gnt    = w_if_win;
    assign ms_gnt    = w_ms_win;

    assign ram_addr  = w_ms_win ? ms_addr : if_addr;
    assign ram_we    = w_ms_win && ms_we;
    assign ram_wdata = ms_wdata;

    // Counts memory-stage wins while fetch is waiting; held under freeze.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_burst_cnt <= 4'd0;
        end else if (w_ms_win && if_req) begin
            if (r_burst_cnt < LP_MAX) begin
                r_burst_cnt <= r_burst_cnt + 4'd1;
            end
        end else if (w_if_win || !if_req) begin
            r_burst_cnt <= 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_owner <= OWN_NONE;
        end else if (w_if_win) begin
            r_rd_owner <= OWN_IF;
        end else if (w_ms_win && !ms_we) begin
            r_rd_owner <= OWN_MS;
        end else begin
            r_rd_owner <= OWN_NONE;
        end
    end

    // A read caught by reset is dropped, including the cycle rst is high.
    assign if_rvalid = (r_rd_owner == OWN_IF) && !rst;
    assign ms_rvalid = (r_rd_owner == OWN_MS) && !rst;

    assign if_rdata  = ram_rdata;
    assign ms_rdata  = ram_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: transaction-level requester model,
// behavioural RAM, expected grants/responses queued and checked by a monitor.
module tb_mem_port_arbiter;

    localparam int MAX = 4;

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
    } ms_tx_t;

    typedef struct packed {
        int          due;
        logic [15:0] data;
    } rsp_t;

    typedef struct packed {
        logic        ig;
        logic        mg;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
    } gnt_t;

    logic        clk = 0;
    logic        rst = 1;
    logic        freeze = 0;
    logic        if_req = 0;
    logic [15:0] if_addr = 0;
    logic        if_gnt, if_rvalid;
    logic [15:0] if_rdata;
    logic        ms_req = 0;
    logic        ms_we = 0;
    logic [15:0] ms_addr = 0;
    logic [15:0] ms_wdata = 0;
    logic        ms_gnt, ms_rvalid;
    logic [15:0] ms_rdata;
    logic [15:0] ram_addr;
    logic        ram_we;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata = 0;

    mem_port_arbiter #(
        .ADDR_W(16), .DATA_W(16), .MAX_MS_BURST(MAX)
    ) dut (
        .clk(clk), .rst(rst), .freeze(freeze),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ms_req(ms_req), .ms_we(ms_we), .ms_addr(ms_addr),
        .ms_wdata(ms_wdata), .ms_gnt(ms_gnt),
        .ms_rvalid(ms_rvalid), .ms_rdata(ms_rdata),
        .ram_addr(ram_addr), .ram_we(ram_we),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] ram_mem [0:65535];
    logic [15:0] shadow  [0:65535];

    always @(posedge clk) begin
        ram_rdata <= ram_mem[ram_addr];
        if (ram_we) ram_mem[ram_addr] <= ram_wdata;
    end

    logic [15:0] if_txq[$];
    ms_tx_t      ms_txq[$];
    rsp_t        if_rq[$];
    rsp_t        ms_rq[$];
    gnt_t        gq[$];

    int vectors = 0;
    int miscompares = 0;
    int streak = 0;
    bit frz_in = 0;
    bit rst_in = 1;

    // One clock cycle: present queued transactions and predict the outcome.
    task automatic step();
        gnt_t   e;
        ms_tx_t t;
        @(posedge clk);
        #1;
        rst    = rst_in;
        freeze = frz_in;
        if_req = (if_txq.size() > 0);
        if (if_req) if_addr = if_txq[0];
        ms_req = (ms_txq.size() > 0);
        if (ms_req) begin
            t = ms_txq[0];
            ms_we    = t.we;
            ms_addr  = t.addr;
            ms_wdata = t.wdata;
        end else begin
            ms_we = 0;
        end
        e = '0;
        if (rst_in) begin
            if_rq.delete();
            ms_rq.delete();
            streak = 0;
        end else begin
            if (!frz_in) begin
                if (ms_req && (!if_req || streak < MAX)) e.mg = 1;
                else if (if_req) e.ig = 1;
            end
            if (e.mg && if_req) begin
                if (streak < MAX) streak++;
            end else if (e.ig || !if_req) begin
                streak = 0;
            end
        end
        e.we    = e.mg && ms_we;
        e.addr  = e.mg ? ms_addr : if_addr;
        e.wdata = ms_wdata;
        if (e.mg) begin
            t = ms_txq.pop_front();
            if (t.we) shadow[t.addr] = t.wdata;
            else ms_rq.push_back('{due: cyc + 1, data: shadow[t.addr]});
        end
        if (e.ig) begin
            if_rq.push_back('{due: cyc + 1, data: shadow[if_addr]});
            void'(if_txq.pop_front());
        end
        gq.push_back(e);
    endtask

    task automatic run_until_empty(input int limit);
        int n = 0;
        while ((if_txq.size() > 0 || ms_txq.size() > 0) && n < limit) begin
            step();
            n++;
        end
        if (if_txq.size() > 0 || ms_txq.size() > 0) begin
            miscompares++;
            $display("FAIL drain_timeout cyc=%0d pending if=%0d ms=%0d required 0",
                     cyc, if_txq.size(), ms_txq.size());
        end
    endtask

    function automatic ms_tx_t mk(input logic we, input logic [15:0] a,
                                  input logic [15:0] d);
        ms_tx_t t;
        t.we = we;
        t.addr = a;
        t.wdata = d;
        return t;
    endfunction

    always @(negedge clk) begin
        gnt_t e;
        rsp_t r;
        if (gq.size() > 0) begin
            e = gq.pop_front();
            vectors++;
            if (if_gnt !== e.ig || ms_gnt !== e.mg || ram_we !== e.we
                || ram_addr !== e.addr || ram_wdata !== e.wdata) begin
                miscompares++;
                $display("FAIL grant cyc=%0d got if=%0b ms=%0b we=%0b a=%h d=%h req if=%0b ms=%0b we=%0b a=%h d=%h",
                         cyc, if_gnt, ms_gnt, ram_we, ram_addr, ram_wdata,
                         e.ig, e.mg, e.we, e.addr, e.wdata);
            end
        end
        vectors++;
        if (if_rq.size() > 0 && if_rq[0].due == cyc) begin
            r = if_rq.pop_front();
            if (if_rvalid !== 1'b1 || if_rdata !== r.data) begin
                miscompares++;
                $display("FAIL if_rsp cyc=%0d got v=%0b d=%h req v=1 d=%h",
                         cyc, if_rvalid, if_rdata, r.data);
            end
        end else if (if_rvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL if_rvalid cyc=%0d got %0b req 0", cyc, if_rvalid);
        end
        vectors++;
        if (ms_rq.size() > 0 && ms_rq[0].due == cyc) begin
            r = ms_rq.pop_front();
            if (ms_rvalid !== 1'b1 || ms_rdata !== r.data) begin
                miscompares++;
                $display("FAIL ms_rsp cyc=%0d got v=%0b d=%h req v=1 d=%h",
                         cyc, ms_rvalid, ms_rdata, r.data);
            end
        end else if (ms_rvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL ms_rvalid cyc=%0d got %0b req 0", cyc, ms_rvalid);
        end
    end

    initial begin
        for (int i = 0; i < 65536; i++) begin
            ram_mem[i] = 16'(i) ^ 16'hA5A5;
            shadow[i]  = 16'(i) ^ 16'hA5A5;
        end

        // Reset with both requesters waiting, then release.
        rst_in = 1;
        if_txq.push_back(16'h0001);
        ms_txq.push_back(mk(1'b0, 16'h0002, 16'h0));
        step();
        step();
        rst_in = 0;
        run_until_empty(10);

        // Fetch alone, consecutive addresses.
        if_txq.push_back(16'h0010);
        if_txq.push_back(16'h0011);
        if_txq.push_back(16'h0012);
        run_until_empty(10);
        step();

        // Contention: fetch held while memory stage streams reads.
        if_txq.push_back(16'h0040);
        for (int i = 0; i < 8; i++)
            ms_txq.push_back(mk(1'b0, 16'h0100 + 16'(i), 16'h0));
        run_until_empty(20);
        step();

        // Write then read back.
        ms_txq.push_back(mk(1'b1, 16'h0200, 16'hBEEF));
        ms_txq.push_back(mk(1'b0, 16'h0200, 16'h0));
        run_until_empty(10);
        step();

        // Freeze in the middle of a contended burst.
        if_txq.push_back(16'h0050);
        for (int i = 0; i < 6; i++)
            ms_txq.push_back(mk(1'b0, 16'h0300 + 16'(i), 16'h0));
        step();
        step();
        frz_in = 1;
        repeat (3) step();
        frz_in = 0;
        run_until_empty(20);
        step();

        // Reset right after a fetch read is granted.
        if_txq.push_back(16'h0060);
        step();
        rst_in = 1;
        step();
        rst_in = 0;
        step();
        step();

        // Randomised traffic on a small address window.
        for (int n = 0; n < 800; n++) begin
            if (if_txq.size() == 0 && ($urandom % 4) != 0)
                if_txq.push_back(16'($urandom % 32));
            if (ms_txq.size() == 0 && ($urandom % 3) != 0)
                ms_txq.push_back(mk(1'($urandom % 2), 16'($urandom % 32),
                                    16'($urandom)));
            frz_in = (($urandom % 12) == 0);
            rst_in = (($urandom % 150) == 0);
            step();
        end
        frz_in = 0;
        rst_in = 0;
        if_txq.delete();
        ms_txq.delete();
        repeat (3) step();
        @(negedge clk);
        #1;
        vectors++;
        if (if_rq.size() != 0 || ms_rq.size() != 0 || gq.size() != 0) begin
            miscompares++;
            $display("FAIL drain cyc=%0d got pending if=%0d ms=%0d g=%0d req 0",
                     cyc, if_rq.size(), ms_rq.size(), gq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port synchronous data/instruction RAM between the fetch stage (read-only) and the memory stage (read/write) of the pipelined 16-bit CPU.
- Grants at most one access per cycle and returns read data one cycle later, tagged to the requester that issued the read.
- The memory stage has priority. A burst counter guarantees fetch forward progress.
- Grant-low is the per-stage stall source the pipeline uses to raise its stage halt inputs.

Parameters:
ADDR_W, 16, RAM word-address width
DATA_W, 16, RAM data width
MAX_MS_BURST, 4, maximum consecutive memory-stage grants while fetch is waiting (range 1..15)

Ports:
clk  in  1  system clock, all state on posedge
rst  in  1  synchronous active-high reset
freeze  in  1  CPU halted; no new grants while high
if_req  in  1  fetch read request; held with if_addr until if_gnt
if_addr  in  ADDR_W  fetch address
if_gnt  out  1  fetch access accepted this cycle (combinational)
if_rvalid  out  1  if_rdata valid (registered)
if_rdata  out  DATA_W  fetch read data
ms_req  in  1  memory-stage request; held with ms_we/ms_addr/ms_wdata until ms_gnt
ms_we  in  1  1 = write, 0 = read
ms_addr  in  ADDR_W  memory-stage address
ms_wdata  in  DATA_W  write data
ms_gnt  out  1  memory-stage access accepted this cycle (combinational)
ms_rvalid  out  1  ms_rdata valid (registered)
ms_rdata  out  DATA_W  memory-stage read data
ram_addr  out  ADDR_W  RAM address (combinational mux)
ram_we  out  1  RAM write enable
ram_wdata  out  DATA_W  RAM write data
ram_rdata  in  DATA_W  RAM read data, valid one cycle after address

Behaviour:
- Reset (rst high at posedge): burst_cnt=0, rd_owner=NONE, if_rvalid=0, ms_rvalid=0.
  - While rst is high, if_gnt, ms_gnt and ram_we are forced to 0.
  - An in-flight read is dropped: no rvalid follows reset.
- Grant logic is combinational from requests, freeze, rst and burst_cnt.
  - freeze=1: no grant to either requester.
  - Only ms_req: ms_gnt=1.
  - Only if_req: if_gnt=1.
  - Both requesting and burst_cnt < MAX_MS_BURST: ms_gnt=1.
  - Both requesting and burst_cnt == MAX_MS_BURST: if_gnt=1.
  - if_gnt and ms_gnt are never both 1.
- RAM mux:
  - ms_gnt: ram_addr=ms_addr, ram_we=ms_we, ram_wdata=ms_wdata.
  - Otherwise: ram_addr=if_addr, ram_we=0, ram_wdata=ms_wdata.
  - ram_we=1 only when ms_gnt and ms_we.
- Burst counter, updated on posedge:
  - ms_gnt && if_req: saturating increment.
  - if_gnt, or !if_req: cleared to 0.
  - Otherwise: held (covers freeze).
- Read tracking, rd_owner in {NONE, IF, MS}, updated every posedge:
  - IF if if_gnt.
  - MS if ms_gnt && !ms_we.
  - NONE otherwise.
- Responses:
  - if_rvalid = (rd_owner==IF) and ms_rvalid = (rd_owner==MS). Both are registered, so latency is one cycle after the grant cycle.
  - if_rdata and ms_rdata both pass ram_rdata through; they are meaningful only with their rvalid.
- Writes produce no rvalid. Back-to-back grants are allowed every cycle (full throughput).
- freeze asserted mid-operation: a read granted in the previous cycle still returns its rvalid.
- Requester rule: after gnt, a requester may change address or drop req on the next cycle. A request without gnt must be held unchanged; the arbiter does not latch requests.

Decomposition:
- Shared CPU package holds: owner encoding constants (NONE=2'd0, IF=2'd1, MS=2'd2) and the ADDR_W/DATA_W defaults.
- No sub-module. The burst counter is too small to justify one.

Test Plan:
- Reset: hold rst for 2 cycles with both requests high -> no grants, ram_we=0, both rvalids 0. Release rst -> ms_gnt on the next evaluation.
- Fetch alone: if_req with addresses 0x0010, 0x0011, 0x0012 on consecutive cycles, RAM model returning addr^0xA5A5 -> if_gnt every cycle; if_rvalid one cycle after each grant with if_rdata 0xA5B5, 0xA5B4, 0xA5B7.
- Contention: if_req held at 0x0040 while ms issues reads to 0x0100..0x0107 with MAX_MS_BURST=4:
  - ms granted for 0x0100..0x0103.
  - Fifth cycle: if_gnt for 0x0040, and the ms request for 0x0104 stalls exactly 1 cycle.
  - ms_rvalid and if_rvalid each align to their own grants.
- Write: ms_we=1, ms_addr=0x0200, ms_wdata=0xBEEF -> ram_we=1 for one cycle and no ms_rvalid. A following read of 0x0200 -> ms_rdata=0xBEEF.
- Freeze: ms read granted at cycle t, freeze=1 from t+1 for 3 cycles with both requests held -> ms_rvalid at t+1, no grants during freeze, burst_cnt unchanged. Grants resume in the first cycle freeze is low.
- Reset mid-read: grant an if read, assert rst the next cycle -> if_rvalid stays 0.
